// File: rtl/div_sequencer.sv
// Sequencer around an external combinational divider: latches operands, waits LATENCY edges,
// then captures a signed quotient (or divide-by-zero) and pulses data_resultRDY for one cycle.
module div_sequencer #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [15:0] data_operandB,
  input  logic [31:0] div_quotient,
  output logic [31:0] div_operandA,
  output logic [15:0] div_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_inputRDY,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  localparam logic [3:0] LOAD = 4'(LATENCY - 1);

  state_t     state, state_nxt;
  logic [3:0] count;
  logic       sign, zero_div;
  logic       start, capture;

  always_comb begin
    data_inputRDY  = (state != SETTLE);
    data_resultRDY = (state == DONE);
    start          = ctrl_DIV & data_inputRDY;
    capture        = (state == SETTLE) && (count == 4'd0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (count == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = start ? SETTLE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count        <= 4'd0;
      div_operandA <= 32'd0;
      div_operandB <= 16'd0;
      sign         <= 1'b0;
      zero_div     <= 1'b0;
    end else if (start) begin
      count        <= LOAD;
      div_operandA <= data_operandA;
      div_operandB <= data_operandB;
      sign         <= data_operandA[31] ^ data_operandB[15];
      zero_div     <= (data_operandB == 16'd0);
    end else if (state == SETTLE && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  // Two's-complement negation wraps naturally: 0x80000000 and 0 map to themselves.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_result    <= 32'd0;
      data_exception <= 1'b0;
    end else if (capture) begin
      if (zero_div) begin
        data_result    <= 32'd0;
        data_exception <= 1'b1;
      end else if (sign) begin
        data_result    <= (~div_quotient) + 32'd1;
        data_exception <= 1'b0;
      end else begin
        data_result    <= div_quotient;
        data_exception <= 1'b0;
      end
    end
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, giving the cycles allowed for the combinational divider to settle; legal range 1..15.
REQ-002 The block SHALL have port clock  input  1  the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port ctrl_DIV  input  1  start request, sampled on the clock edge.
REQ-005 The block SHALL have port data_operandA  input  32  signed dividend.
REQ-006 The block SHALL have port data_operandB  input  16  signed divisor.
REQ-007 The block SHALL have port div_quotient  input  32  unsigned quotient magnitude returned by the combinational divider.
REQ-008 The block SHALL have port div_operandA  output  32  registered dividend driven to the divider.
REQ-009 The block SHALL have port div_operandB  output  16  registered divisor driven to the divider.
REQ-010 The block SHALL have port data_result  output  32  registered signed quotient.
REQ-011 The block SHALL have port data_exception  output  1  divide-by-zero flag, qualified by data_resultRDY.
REQ-012 The block SHALL have port data_inputRDY  output  1  high when a start is accepted.
REQ-013 The block SHALL have port data_resultRDY  output  1  one-cycle pulse; data_result and data_exception are valid.

Function
REQ-014 The block SHALL implement the states IDLE, SETTLE and DONE.
REQ-015 The block SHALL drive data_inputRDY high in IDLE and DONE, and low in SETTLE.
REQ-016 An edge with ctrl_DIV=1 and data_inputRDY=1 SHALL be a start edge E0.
REQ-017 At E0 the block SHALL latch data_operandA into div_operandA and data_operandB into div_operandB.
REQ-018 At E0 the block SHALL latch sign = A[31] XOR B[15] and zero_div = (B == 0).
REQ-019 At E0 the block SHALL load a 4-bit counter with LATENCY-1 and enter SETTLE.
REQ-020 In SETTLE the counter SHALL decrement by 1 per edge.
REQ-021 On the edge where the counter is 0 in SETTLE (edge E_LATENCY), the block SHALL capture the result and enter DONE.
REQ-022 Result capture: if zero_div, data_result SHALL be 0 and data_exception 1.
REQ-023 Result capture: else if sign, data_result SHALL be (~div_quotient)+1 modulo 2^32, and data_exception 0.
REQ-024 Result capture: else data_result SHALL be div_quotient, and data_exception 0.
REQ-025 data_resultRDY SHALL be high exactly while in DONE, i.e. for the one cycle after E_LATENCY.
REQ-026 From DONE the block SHALL go to SETTLE on a start edge, otherwise to IDLE.
REQ-027 data_resultRDY SHALL still complete its one-cycle pulse when a start occurs in DONE (back-to-back operation).
REQ-028 ctrl_DIV SHALL be ignored in SETTLE; the latched operands, sign and counter SHALL not change.
REQ-029 div_operandA/B SHALL hold their values from E0 until the next start edge.
REQ-030 data_result and data_exception SHALL hold their values until the next capture.
REQ-031 Negating a quotient of 0x80000000 SHALL yield 0x80000000, and negating 0 SHALL yield 0.

Reset
REQ-032 While reset_n=0, the block SHALL immediately, without waiting for a clock edge, set: state IDLE, counter 0, div_operandA 0, div_operandB 0, sign 0, zero_div 0, data_result 0, data_exception 0, data_resultRDY 0, data_inputRDY 1.
REQ-033 Reset asserted during SETTLE or DONE SHALL abort the operation; no data_resultRDY pulse SHALL follow reset release.
REQ-034 The first start edge after reset release SHALL be accepted normally.

Verification
REQ-035 A=100, B=7, model quotient 14, LATENCY=4 -> data_resultRDY high in the cycle after the 4th edge following E0; data_result=14; data_exception=0.
REQ-036 A=-100 (0xFFFFFF9C), B=7, quotient 14 -> data_result=0xFFFFFFF2; A=-100, B=-7 -> data_result=14.
REQ-037 A=5, B=0 -> data_result=0, data_exception=1, one data_resultRDY pulse; data_inputRDY low during SETTLE.
REQ-038 ctrl_DIV pulsed with new operands in SETTLE -> ignored; original result delivered; div_operandA unchanged.
REQ-039 ctrl_DIV held high continuously -> start accepted in each DONE cycle; data_resultRDY pulses every LATENCY+1 cycles.
REQ-040 reset_n driven low two edges after E0 -> outputs reach reset values immediately; no data_resultRDY pulse after release; the next start edge completes normally.
